// File: rtl/regbank_arb_pkg.sv
// regbank_arb_pkg
//   Shared types and constants for the register bank write-port arbiter.
//   - DEFAULT_DATA_WIDTH / DEFAULT_ADDR_WIDTH : default datapath and address widths
//   - STARVE_CNT_W                            : width of the long-latency starvation counter
//   - grant_t                                 : write-port owner for the current cycle
package regbank_arb_pkg;

  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam int DEFAULT_ADDR_WIDTH = 5;
  localparam int STARVE_CNT_W       = 4;

  typedef enum logic [1:0] {
    GRANT_NONE = 2'd0,
    GRANT_WB   = 2'd1,
    GRANT_LU   = 2'd2
  } grant_t;

endpackage

// File: rtl/register_scoreboard.sv
// register_scoreboard
//   One busy bit per architectural register. A bit is set when a long-latency
//   op is issued to that register and cleared when its result is written.
//   Ports:
//     clk, reset            : clock, asynchronous active-high reset
//     set_valid, set_addr   : long-latency issue (marks destination busy)
//     clr_valid, clr_addr   : long-latency result written (clears busy)
//     rs1_addr, rs2_addr    : decode read addresses
//     hazard                : either read address is busy (combinational)
module register_scoreboard #(
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  set_valid,
  input  logic [ADDR_WIDTH-1:0] set_addr,
  input  logic                  clr_valid,
  input  logic [ADDR_WIDTH-1:0] clr_addr,
  input  logic [ADDR_WIDTH-1:0] rs1_addr,
  input  logic [ADDR_WIDTH-1:0] rs2_addr,
  output logic                  hazard
);

  localparam int NUM_REGS = 1 << ADDR_WIDTH;

  logic [NUM_REGS-1:0] busy;
  logic [NUM_REGS-1:0] busy_next;

  // Clear is applied first so that a same-cycle issue to the same register
  // leaves it busy: the new op's result is still outstanding. Issues to x0
  // are ignored, so busy[0] can never become 1.
  always_comb begin
    busy_next = busy;
    if (clr_valid) begin
      busy_next[clr_addr] = 1'b0;
    end
    if (set_valid && (set_addr != '0)) begin
      busy_next[set_addr] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy <= '0;
    end else begin
      busy <= busy_next;
    end
  end

  assign hazard = busy[rs1_addr] | busy[rs2_addr];

endmodule

// File: rtl/register_write_arbiter.sv
// register_write_arbiter
//   Shares the register bank write port between the writeback path (WB) and
//   an out-of-order long-latency unit (LU), and tracks outstanding LU
//   destinations for read-after-write hazard detection.
//   Build option: define REGWRITE_STARVE_GUARD_EN to enable the starvation
//   counter that lets LU pre-empt WB after STARVE_LIMIT denied cycles.
//   Without it WB always wins and wb_stall is tied low.
//   Ports:
//     clk, reset                      : clock, asynchronous active-high reset
//     wb_valid/wb_addr/wb_data        : writeback request
//     wb_stall                        : writeback denied this cycle
//     lu_valid/lu_addr/lu_data        : long-latency result
//     lu_ready                        : long-latency result accepted
//     issue_valid/issue_addr          : long-latency issue (marks busy)
//     rs1_addr, rs2_addr, hazard      : decode hazard lookup
//     rf_write_enable/addr/data       : register bank write port
//
//   Handshake: an LU result transfers in a cycle where lu_valid & lu_ready.
//   lu_ready is computed without looking at lu_valid, and the producer must
//   hold lu_addr/lu_data stable while lu_valid is high and lu_ready is low.
//   WB has no ready; wb_stall tells the pipeline to hold its request.
module register_write_arbiter
  import regbank_arb_pkg::*;
#(
  parameter int DATA_WIDTH   = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH   = DEFAULT_ADDR_WIDTH,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wb_valid,
  input  logic [ADDR_WIDTH-1:0] wb_addr,
  input  logic [DATA_WIDTH-1:0] wb_data,
  output logic                  wb_stall,
  input  logic                  lu_valid,
  input  logic [ADDR_WIDTH-1:0] lu_addr,
  input  logic [DATA_WIDTH-1:0] lu_data,
  output logic                  lu_ready,
  input  logic                  issue_valid,
  input  logic [ADDR_WIDTH-1:0] issue_addr,
  input  logic [ADDR_WIDTH-1:0] rs1_addr,
  input  logic [ADDR_WIDTH-1:0] rs2_addr,
  output logic                  hazard,
  output logic                  rf_write_enable,
  output logic [ADDR_WIDTH-1:0] rf_write_addr,
  output logic [DATA_WIDTH-1:0] rf_write_data
);

  generate
    if ((STARVE_LIMIT < 1) || (STARVE_LIMIT > 15)) begin : g_bad_limit
      $error("STARVE_LIMIT must be in 1..15");
    end
  endgenerate

  grant_t grant;
  logic   starve;
  logic   lu_fire;

`ifdef REGWRITE_STARVE_GUARD_EN
  localparam logic [STARVE_CNT_W-1:0] LIMIT = STARVE_CNT_W'(STARVE_LIMIT);

  logic [STARVE_CNT_W-1:0] starve_cnt;

  assign starve = (starve_cnt == LIMIT);

  // Counts consecutive cycles an LU result sat waiting. Any gap in
  // lu_valid or a completed transfer restarts the count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starve_cnt <= '0;
    end else if (!lu_valid || lu_fire) begin
      starve_cnt <= '0;
    end else if (starve_cnt != LIMIT) begin
      starve_cnt <= starve_cnt + STARVE_CNT_W'(1);
    end
  end
`else
  assign starve = 1'b0;
`endif

  assign lu_ready = ~wb_valid | starve;
  assign wb_stall = wb_valid & starve;
  assign lu_fire  = lu_valid & lu_ready;

  // lu_fire already implies WB is idle or being overridden.
  always_comb begin
    grant = GRANT_NONE;
    if (wb_valid && !starve) begin
      grant = GRANT_WB;
    end else if (lu_fire) begin
      grant = GRANT_LU;
    end
  end

  always_comb begin
    rf_write_addr = '0;
    rf_write_data = '0;
    case (grant)
      GRANT_WB: begin
        rf_write_addr = wb_addr;
        rf_write_data = wb_data;
      end
      GRANT_LU: begin
        rf_write_addr = lu_addr;
        rf_write_data = lu_data;
      end
      default: begin
        rf_write_addr = '0;
        rf_write_data = '0;
      end
    endcase
  end

  // x0 writes still complete their handshake; only the bank write is dropped.
  assign rf_write_enable = (grant != GRANT_NONE) && (rf_write_addr != '0);

  register_scoreboard #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_scoreboard (
    .clk       (clk),
    .reset     (reset),
    .set_valid (issue_valid),
    .set_addr  (issue_addr),
    .clr_valid (lu_fire),
    .clr_addr  (lu_addr),
    .rs1_addr  (rs1_addr),
    .rs2_addr  (rs2_addr),
    .hazard    (hazard)
  );

endmodule

// File: tb/tb_register_write_arbiter.sv
// tb_register_write_arbiter
//   Self-checking bench for register_write_arbiter. Inputs are driven 1 ns
//   after the rising edge; outputs are sampled on the falling edge. Every
//   expected register bank write is queued when its stimulus is driven and
//   compared when the DUT asserts rf_write_enable.
module tb_register_write_arbiter;

  localparam int DW = 32;
  localparam int AW = 5;

  logic          clk;
  logic          reset;
  logic          wb_valid;
  logic [AW-1:0] wb_addr;
  logic [DW-1:0] wb_data;
  logic          wb_stall;
  logic          lu_valid;
  logic [AW-1:0] lu_addr;
  logic [DW-1:0] lu_data;
  logic          lu_ready;
  logic          issue_valid;
  logic [AW-1:0] issue_addr;
  logic [AW-1:0] rs1_addr;
  logic [AW-1:0] rs2_addr;
  logic          hazard;
  logic          rf_write_enable;
  logic [AW-1:0] rf_write_addr;
  logic [DW-1:0] rf_write_data;

  int checks = 0;
  int errors = 0;

  logic [AW+DW-1:0] exp_q[$];
  logic [AW+DW-1:0] exp_w;

  register_write_arbiter #(
    .DATA_WIDTH   (DW),
    .ADDR_WIDTH   (AW),
    .STARVE_LIMIT (4)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .wb_valid        (wb_valid),
    .wb_addr         (wb_addr),
    .wb_data         (wb_data),
    .wb_stall        (wb_stall),
    .lu_valid        (lu_valid),
    .lu_addr         (lu_addr),
    .lu_data         (lu_data),
    .lu_ready        (lu_ready),
    .issue_valid     (issue_valid),
    .issue_addr      (issue_addr),
    .rs1_addr        (rs1_addr),
    .rs2_addr        (rs2_addr),
    .hazard          (hazard),
    .rf_write_enable (rf_write_enable),
    .rf_write_addr   (rf_write_addr),
    .rf_write_data   (rf_write_data)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete (got running, need finished)");
    $fatal(1, "timeout");
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (!reset && rf_write_enable) begin
      if (exp_q.size() == 0) begin
        check("wr_unexpected", 64'({rf_write_addr, rf_write_data}), 64'(0));
      end else begin
        exp_w = exp_q.pop_front();
        check("wr", 64'({rf_write_addr, rf_write_data}), 64'(exp_w));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic idle();
    wb_valid    = 1'b0;
    wb_addr     = '0;
    wb_data     = '0;
    lu_valid    = 1'b0;
    lu_addr     = '0;
    lu_data     = '0;
    issue_valid = 1'b0;
    issue_addr  = '0;
  endtask

  task automatic drive_wb(input logic [AW-1:0] a, input logic [DW-1:0] d);
    wb_valid = 1'b1;
    wb_addr  = a;
    wb_data  = d;
  endtask

  task automatic drive_lu(input logic [AW-1:0] a, input logic [DW-1:0] d);
    lu_valid = 1'b1;
    lu_addr  = a;
    lu_data  = d;
  endtask

  // LU result held against continuous writeback, starting from a clear counter.
  task automatic run_starve(input logic [AW-1:0] la, input logic [DW-1:0] ld);
    logic [DW-1:0] d;
    next_cycle();
    drive_lu(la, ld);
`ifdef REGWRITE_STARVE_GUARD_EN
    for (int i = 0; i < 4; i++) begin
      if (i > 0) next_cycle();
      d = $urandom;
      drive_wb(AW'(16 + i), d);
      exp_q.push_back({AW'(16 + i), d});
      sample();
      check("starve_deny_ready", 64'(lu_ready), 64'(0));
      check("starve_deny_stall", 64'(wb_stall), 64'(0));
    end
    next_cycle();
    drive_wb(AW'(20), $urandom);
    exp_q.push_back({la, ld});
    sample();
    check("starve_grant_ready", 64'(lu_ready), 64'(1));
    check("starve_grant_stall", 64'(wb_stall), 64'(1));
    next_cycle();
    d = $urandom;
    drive_wb(AW'(21), d);
    exp_q.push_back({AW'(21), d});
    sample();
    check("starve_back_ready", 64'(lu_ready), 64'(0));
    check("starve_back_stall", 64'(wb_stall), 64'(0));
`else
    for (int i = 0; i < 8; i++) begin
      if (i > 0) next_cycle();
      d = $urandom;
      drive_wb(AW'(16 + i), d);
      exp_q.push_back({AW'(16 + i), d});
      sample();
      check("noguard_deny_ready", 64'(lu_ready), 64'(0));
      check("noguard_deny_stall", 64'(wb_stall), 64'(0));
    end
    next_cycle();
    wb_valid = 1'b0;
    exp_q.push_back({la, ld});
    sample();
    check("noguard_lu_ready", 64'(lu_ready), 64'(1));
`endif
    next_cycle();
    idle();
  endtask

  // ---------------- main stimulus ----------------
  initial begin
    idle();
    rs1_addr = '0;
    rs2_addr = '0;
    reset    = 1'b1;
    sample();
    check("rst_hazard",   64'(hazard),          64'(0));
    check("rst_wb_stall", 64'(wb_stall),        64'(0));
    check("rst_lu_ready", 64'(lu_ready),        64'(1));
    check("rst_we",       64'(rf_write_enable), 64'(0));
    next_cycle();
    reset = 1'b0;

    // WB only
    next_cycle();
    drive_wb(AW'(5), 32'hDEAD_BEEF);
    exp_q.push_back({AW'(5), 32'hDEAD_BEEF});
    sample();
    check("wb_we",    64'(rf_write_enable), 64'(1));
    check("wb_addr",  64'(rf_write_addr),   64'(5));
    check("wb_stall", 64'(wb_stall),        64'(0));

    // Collision: WB wins, LU granted next cycle
    next_cycle();
    drive_wb(AW'(3), 32'h0000_AAAA);
    drive_lu(AW'(7), 32'h0000_BBBB);
    exp_q.push_back({AW'(3), 32'h0000_AAAA});
    sample();
    check("coll_lu_ready", 64'(lu_ready), 64'(0));
    next_cycle();
    wb_valid = 1'b0;
    exp_q.push_back({AW'(7), 32'h0000_BBBB});
    sample();
    check("coll_lu_ready2", 64'(lu_ready),      64'(1));
    check("coll_lu_addr",   64'(rf_write_addr), 64'(7));
    next_cycle();
    idle();

    // Starvation
    run_starve(AW'(12), 32'h0C0C_0C0C);

    // Scoreboard
    next_cycle();
    issue_valid = 1'b1;
    issue_addr  = AW'(9);
    rs1_addr    = AW'(9);
    sample();
    check("sb_issue_cycle", 64'(hazard), 64'(0));
    next_cycle();
    issue_valid = 1'b0;
    sample();
    check("sb_busy_rs1", 64'(hazard), 64'(1));
    rs1_addr = '0;
    rs2_addr = AW'(9);
    #1;
    check("sb_busy_rs2", 64'(hazard), 64'(1));
    next_cycle();
    drive_lu(AW'(9), 32'h0000_0909);
    exp_q.push_back({AW'(9), 32'h0000_0909});
    sample();
    check("sb_complete_cycle", 64'(hazard), 64'(1));
    next_cycle();
    idle();
    sample();
    check("sb_cleared", 64'(hazard), 64'(0));
    next_cycle();
    issue_valid = 1'b1;
    issue_addr  = AW'(9);
    next_cycle();
    drive_lu(AW'(9), 32'h0000_1919);
    exp_q.push_back({AW'(9), 32'h0000_1919});
    sample();
    check("sb_set_clr_cycle", 64'(hazard), 64'(1));
    next_cycle();
    idle();
    sample();
    check("sb_set_wins", 64'(hazard), 64'(1));
    next_cycle();
    drive_lu(AW'(9), 32'h0000_2929);
    exp_q.push_back({AW'(9), 32'h0000_2929});
    next_cycle();
    idle();
    sample();
    check("sb_final_clear", 64'(hazard), 64'(0));

    // x0
    next_cycle();
    drive_lu(AW'(0), 32'h0000_1234);
    sample();
    check("x0_lu_ready", 64'(lu_ready),        64'(1));
    check("x0_we",       64'(rf_write_enable), 64'(0));
    next_cycle();
    idle();
    issue_valid = 1'b1;
    issue_addr  = AW'(0);
    rs1_addr    = '0;
    rs2_addr    = '0;
    next_cycle();
    idle();
    sample();
    check("x0_hazard", 64'(hazard), 64'(0));

    // Mid-operation reset: x4, x6 busy and three LU denials accumulated
    next_cycle();
    issue_valid = 1'b1;
    issue_addr  = AW'(4);
    next_cycle();
    issue_addr  = AW'(6);
    next_cycle();
    issue_valid = 1'b0;
    rs1_addr    = AW'(4);
    rs2_addr    = AW'(6);
    drive_lu(AW'(13), 32'h0D0D_0D0D);
    for (int i = 0; i < 3; i++) begin
      if (i > 0) next_cycle();
      drive_wb(AW'(24 + i), 32'(100 + i));
      exp_q.push_back({AW'(24 + i), 32'(100 + i)});
      sample();
      check("pre_rst_ready", 64'(lu_ready), 64'(0));
    end
    check("pre_rst_hazard", 64'(hazard), 64'(1));
    next_cycle();
    reset = 1'b1;
    #1;
    check("mid_rst_hazard",   64'(hazard),   64'(0));
    check("mid_rst_wb_stall", 64'(wb_stall), 64'(0));
    idle();
    rs1_addr = AW'(6);
    rs2_addr = AW'(4);
    next_cycle();
    reset = 1'b0;
    sample();
    check("post_rst_hazard", 64'(hazard), 64'(0));
    run_starve(AW'(14), 32'h0E0E_0E0E);

    next_cycle();
    sample();
    check("queue_empty", 64'(exp_q.size()), 64'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
